// File: rtl/fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_prefetch_queue
//
// Instruction-fetch front end.  It owns the fetch PC, issues one read at a time
// to a stalling instruction memory and buffers the returned instructions,
// together with their PCs, in a DEPTH-entry FIFO.  This decouples memory stalls
// from decode stalls.  A taken-branch redirect flushes the queue and squashes
// any read that is still in flight.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   redirect_valid  taken branch/jump: flush the queue and load redirect_pc
//   redirect_pc     redirect target address
//   halt            stop issuing new reads; an in-flight read still completes
//   imem_rd         read request to the instruction memory
//   imem_addr       read address, held constant while the read is outstanding
//   imem_stall      memory busy indication
//   imem_done       read data valid this cycle
//   imem_data       returned instruction
//   deq_ready       decode accepts the head entry
//   instr_valid     queue is non-empty
//   instr           head instruction
//   instr_pc        PC of the head instruction
//   instr_pc_next   instr_pc + PC_STEP, wrapping modulo 2^ADDR_W
// -----------------------------------------------------------------------------
module fetch_prefetch_queue #(
    parameter int unsigned       ADDR_W   = 32'd16,
    parameter int unsigned       INSTR_W  = 32'd16,
    parameter int unsigned       DEPTH    = 32'd4,
    parameter int unsigned       PC_STEP  = 32'd2,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               imem_rd,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_stall,
    input  logic               imem_done,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               deq_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [ADDR_W-1:0]  instr_pc_next
);

    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam int unsigned       CNT_W    = PTR_W + 32'd1;
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
    localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0]  PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]  PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Registered state
    state_t             state_r;
    logic [ADDR_W-1:0]  fetch_pc_r;      // next address to request
    logic [ADDR_W-1:0]  addr_r;          // request address; equals fetch_pc_r in IDLE
    logic               squash_r;        // drop the outstanding response
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [INSTR_W-1:0] instr_mem_r [DEPTH];
    logic [ADDR_W-1:0]  pc_mem_r    [DEPTH];
    logic               instr_valid_r;
    logic [INSTR_W-1:0] instr_r;
    logic [ADDR_W-1:0]  instr_pc_r;
    logic [ADDR_W-1:0]  instr_pc_next_r;

    // Next-state / qualifier signals
    logic               issue_s;
    logic               push_s;
    logic               pop_s;
    state_t             state_nxt_s;
    logic               squash_nxt_s;
    logic [ADDR_W-1:0]  fetch_pc_nxt_s;
    logic [ADDR_W-1:0]  addr_nxt_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [PTR_W-1:0]   rd_ptr_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [CNT_W-1:0]   remain_s;
    logic               head_load_s;
    logic [INSTR_W-1:0] head_instr_s;
    logic [ADDR_W-1:0]  head_pc_s;

    // The request is simply held until done, so stall carries no extra
    // information for this block.
    logic unused_stall_s;
    assign unused_stall_s = imem_stall;

    // Issue, push and pop qualification.  Only one read is ever outstanding
    // and issue happens from IDLE only, so the credit check against count_r
    // alone guarantees the response a free slot.
    always_comb begin
        issue_s = (state_r == S_IDLE) & ~rst & ~halt & ~redirect_valid
                  & (count_r < DEPTH_C);
        push_s  = (state_r == S_WAIT) & imem_done & ~squash_r & ~redirect_valid;
        pop_s   = (count_r != CNT_ZERO) & deq_ready & ~redirect_valid;
        imem_rd = ~rst & ((state_r == S_WAIT) | issue_s);
    end

    // Issue FSM next state and squash tracking
    always_comb begin
        state_nxt_s  = state_r;
        squash_nxt_s = squash_r;
        case (state_r)
            S_IDLE: begin
                squash_nxt_s = 1'b0;
                if (issue_s) begin
                    state_nxt_s = S_WAIT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (imem_done) begin
                    // Read completes; a redirect in the same cycle already
                    // blocked the push, so nothing is left to squash.
                    state_nxt_s  = S_IDLE;
                    squash_nxt_s = 1'b0;
                end else if (redirect_valid) begin
                    state_nxt_s  = S_WAIT;
                    squash_nxt_s = 1'b1;
                end else begin
                    state_nxt_s  = S_WAIT;
                    squash_nxt_s = squash_r;
                end
            end
            default: begin
                state_nxt_s  = S_IDLE;
                squash_nxt_s = 1'b0;
            end
        endcase
    end

    // Fetch PC and request address next values
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        addr_nxt_s     = addr_r;
        if (redirect_valid) begin
            fetch_pc_nxt_s = redirect_pc;
        end else if (push_s) begin
            fetch_pc_nxt_s = fetch_pc_r + STEP;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end
        // The address must stay put while a read is outstanding, even across
        // a redirect; otherwise it follows the fetch PC.
        if (state_nxt_s == S_WAIT) begin
            addr_nxt_s = addr_r;
        end else begin
            addr_nxt_s = fetch_pc_nxt_s;
        end
    end

    // Queue occupancy and pointer next values
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        if (redirect_valid) begin
            count_nxt_s  = CNT_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            wr_ptr_nxt_s = PTR_ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
        end
    end

    // Next head entry for the registered outputs.  If the queue would be
    // empty after the pop, the head is the entry being pushed right now.
    always_comb begin
        remain_s     = count_r - {{(CNT_W-1){1'b0}}, pop_s};
        head_load_s  = 1'b0;
        head_instr_s = instr_r;
        head_pc_s    = instr_pc_r;
        if (redirect_valid) begin
            head_load_s = 1'b0;
        end else if (remain_s != CNT_ZERO) begin
            head_load_s  = 1'b1;
            head_instr_s = instr_mem_r[rd_ptr_nxt_s];
            head_pc_s    = pc_mem_r[rd_ptr_nxt_s];
        end else if (push_s) begin
            head_load_s  = 1'b1;
            head_instr_s = imem_data;
            head_pc_s    = addr_r;
        end else begin
            head_load_s = 1'b0;
        end
    end

    // Queue storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            instr_mem_r[wr_ptr_r] <= imem_data;
            pc_mem_r[wr_ptr_r]    <= addr_r;
        end
    end

    // Control state, pointers and registered head outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= S_IDLE;
            fetch_pc_r      <= RESET_PC;
            addr_r          <= RESET_PC;
            squash_r        <= 1'b0;
            count_r         <= CNT_ZERO;
            rd_ptr_r        <= PTR_ZERO;
            wr_ptr_r        <= PTR_ZERO;
            instr_valid_r   <= 1'b0;
            instr_r         <= {INSTR_W{1'b0}};
            instr_pc_r      <= RESET_PC;
            instr_pc_next_r <= RESET_PC + STEP;
        end else begin
            state_r       <= state_nxt_s;
            fetch_pc_r    <= fetch_pc_nxt_s;
            addr_r        <= addr_nxt_s;
            squash_r      <= squash_nxt_s;
            count_r       <= count_nxt_s;
            rd_ptr_r      <= rd_ptr_nxt_s;
            wr_ptr_r      <= wr_ptr_nxt_s;
            instr_valid_r <= (count_nxt_s != CNT_ZERO);
            if (head_load_s) begin
                instr_r         <= head_instr_s;
                instr_pc_r      <= head_pc_s;
                instr_pc_next_r <= head_pc_s + STEP;
            end
        end
    end

    assign imem_addr     = addr_r;
    assign instr_valid   = instr_valid_r;
    assign instr         = instr_r;
    assign instr_pc      = instr_pc_r;
    assign instr_pc_next = instr_pc_next_r;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_prefetch_queue
//
// Directed bench for fetch_prefetch_queue (default parameters: 16-bit address
// and instruction, DEPTH 4, PC_STEP 2, RESET_PC 0).  Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 time unit after that.
// -----------------------------------------------------------------------------
module tb_fetch_prefetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_stall;
    logic        imem_done;
    logic [15:0] imem_data;
    logic        deq_ready;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_next;

    int checks;
    int errors;

    fetch_prefetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_stall     (imem_stall),
        .imem_done      (imem_done),
        .imem_data      (imem_data),
        .deq_ready      (deq_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc_next  (instr_pc_next)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [15:0] d, input logic [15:0] pc,
                              input logic [15:0] pcn);
        chk1 ({tag, "_valid"}, instr_valid, 1'b1);
        chk16({tag, "_instr"}, instr, d);
        chk16({tag, "_pc"}, instr_pc, pc);
        chk16({tag, "_pcnext"}, instr_pc_next, pcn);
    endtask

    // Called in a cycle where a read to a is being issued: answer it with
    // 1-cycle latency and return in the cycle the entry becomes visible.
    task automatic issue_and_serve(input logic [15:0] a, input logic [15:0] d);
        chk1 ("issue_rd", imem_rd, 1'b1);
        chk16("issue_addr", imem_addr, a);
        next_cycle();
        imem_done = 1'b1;
        imem_data = d;
        next_cycle();
        imem_done = 1'b0;
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        halt           = 1'b0;
        imem_stall     = 1'b0;
        imem_done      = 1'b0;
        imem_data      = 16'h0000;
        deq_ready      = 1'b1;

        // Reset values
        next_cycle();
        next_cycle();
        chk1 ("rst_rd", imem_rd, 1'b0);
        chk16("rst_addr", imem_addr, 16'h0000);
        chk1 ("rst_valid", instr_valid, 1'b0);
        chk16("rst_instr", instr, 16'h0000);
        chk16("rst_pc", instr_pc, 16'h0000);
        chk16("rst_pcnext", instr_pc_next, 16'h0002);

        // First read in the first cycle out of reset; 1-cycle memory
        rst = 1'b0;
        #1;
        chk1("first_rd", imem_rd, 1'b1);
        issue_and_serve(16'h0000, 16'h1111);
        check_head("seq0", 16'h1111, 16'h0000, 16'h0002);
        issue_and_serve(16'h0002, 16'h2222);
        check_head("seq1", 16'h2222, 16'h0002, 16'h0004);
        issue_and_serve(16'h0004, 16'h3333);
        check_head("seq2", 16'h3333, 16'h0004, 16'h0006);

        // Redirect to 0x0040 while the read to 0x0006 is stalled
        deq_ready = 1'b0;
        #1;
        chk1 ("rdir_issue_rd", imem_rd, 1'b1);
        chk16("rdir_issue_addr", imem_addr, 16'h0006);
        next_cycle();
        imem_stall = 1'b1;
        #1;
        chk1("rdir_hold_valid", instr_valid, 1'b1);
        next_cycle();
        chk16("rdir_hold_addr", imem_addr, 16'h0006);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        #1;
        chk1("rdir_rd_held", imem_rd, 1'b1);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk1 ("rdir_flushed", instr_valid, 1'b0);
        chk16("rdir_addr_const", imem_addr, 16'h0006);
        next_cycle();
        next_cycle();
        imem_stall = 1'b0;
        imem_done  = 1'b1;
        imem_data  = 16'h6666;
        next_cycle();
        imem_done = 1'b0;
        #1;
        chk1("rdir_dropped", instr_valid, 1'b0);
        issue_and_serve(16'h0040, 16'h4040);
        check_head("rdir_first", 16'h4040, 16'h0040, 16'h0042);

        // Redirect and done in the same cycle: response dropped
        next_cycle();
        imem_done      = 1'b1;
        imem_data      = 16'hBAD1;
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0080;
        deq_ready      = 1'b1;
        #1;
        chk1("same_pre_valid", instr_valid, 1'b1);
        next_cycle();
        imem_done      = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk1("same_flushed", instr_valid, 1'b0);
        issue_and_serve(16'h0080, 16'h8080);
        check_head("same_next", 16'h8080, 16'h0080, 16'h0082);

        // Redirect to 0xFFFE from IDLE, then PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        #1;
        chk1("wrap_no_issue", imem_rd, 1'b0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        chk1("wrap_flushed", instr_valid, 1'b0);
        issue_and_serve(16'hFFFE, 16'hEEEE);
        check_head("wrap", 16'hEEEE, 16'hFFFE, 16'h0000);
        chk1 ("wrap_next_rd", imem_rd, 1'b1);
        chk16("wrap_next_addr", imem_addr, 16'h0000);

        // Halt mid-read: read completes, nothing further issues
        next_cycle();
        halt = 1'b1;
        #1;
        chk1("halt_inflight_rd", imem_rd, 1'b1);
        imem_done = 1'b1;
        imem_data = 16'h0A0A;
        next_cycle();
        imem_done = 1'b0;
        #1;
        check_head("halt_enq", 16'h0A0A, 16'h0000, 16'h0002);
        chk1("halt_no_rd0", imem_rd, 1'b0);
        next_cycle();
        chk1 ("halt_drained", instr_valid, 1'b0);
        chk1 ("halt_no_rd1", imem_rd, 1'b0);
        chk16("halt_pc_frozen", imem_addr, 16'h0002);
        next_cycle();
        halt = 1'b0;
        #1;
        chk1 ("unhalt_rd", imem_rd, 1'b1);
        chk16("unhalt_addr", imem_addr, 16'h0002);

        // Reset during WAIT; late done ignored
        next_cycle();
        rst = 1'b1;
        #1;
        chk1("rstw_rd", imem_rd, 1'b0);
        next_cycle();
        imem_done = 1'b1;
        imem_data = 16'hDEAD;
        #1;
        chk1 ("rstw_rd2", imem_rd, 1'b0);
        chk16("rstw_addr", imem_addr, 16'h0000);
        chk1 ("rstw_valid", instr_valid, 1'b0);
        chk16("rstw_instr", instr, 16'h0000);
        chk16("rstw_pc", instr_pc, 16'h0000);
        chk16("rstw_pcnext", instr_pc_next, 16'h0002);
        next_cycle();
        rst       = 1'b0;
        deq_ready = 1'b0;
        #1;
        chk1 ("rstw_first_rd", imem_rd, 1'b1);
        chk16("rstw_first_addr", imem_addr, 16'h0000);
        next_cycle();
        imem_done = 1'b0;
        #1;
        chk1("rstw_stale_ignored", instr_valid, 1'b0);

        // Fill with deq_ready=0: exactly DEPTH reads, then stop
        imem_done = 1'b1;
        imem_data = 16'h1000;
        next_cycle();
        imem_done = 1'b0;
        #1;
        check_head("fill0", 16'h1000, 16'h0000, 16'h0002);
        issue_and_serve(16'h0002, 16'h1002);
        issue_and_serve(16'h0004, 16'h1004);
        issue_and_serve(16'h0006, 16'h1006);
        chk1("full_no_rd0", imem_rd, 1'b0);
        check_head("full_head", 16'h1000, 16'h0000, 16'h0002);
        next_cycle();
        chk1("full_no_rd1", imem_rd, 1'b0);
        next_cycle();
        deq_ready = 1'b1;
        #1;
        chk1("full_no_rd2", imem_rd, 1'b0);
        next_cycle();
        deq_ready = 1'b0;
        #1;
        check_head("after_pop", 16'h1002, 16'h0002, 16'h0004);
        issue_and_serve(16'h0008, 16'h1008);
        chk1("refull_no_rd", imem_rd, 1'b0);

        // Drain and check order
        deq_ready = 1'b1;
        next_cycle();
        check_head("drain1", 16'h1004, 16'h0004, 16'h0006);
        next_cycle();
        check_head("drain2", 16'h1006, 16'h0006, 16'h0008);
        next_cycle();
        check_head("drain3", 16'h1008, 16'h0008, 16'h000A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
